// File: rtl/aes128_key_expander_pkg.sv
// rtl/aes128_key_expander_pkg.sv - shared AES-128 key-expansion constants, state encoding, GF helper
package aes128_key_expander_pkg;

    localparam int         AES128_NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT         = 8'h01;
    localparam logic [7:0] GF_REDUCE         = 8'h1B;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_expander_if.sv
// rtl/aes128_key_expander_if.sv - key load and round-key handshake bundle
interface aes128_key_expander_if;

    logic         start;
    logic [0:127] key_in;
    logic [0:127] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    modport slave (
        input  start, key_in, rk_ready,
        output round_key, round_idx, rk_valid, busy, done
    );

    modport master (
        output start, key_in, rk_ready,
        input  round_key, round_idx, rk_valid, busy, done
    );

endinterface

// File: rtl/aes128_key_expander_g_function.sv
// rtl/aes128_key_expander_g_function.sv - RotWord followed by SubWord on one 32-bit word
module aes128_key_expander_g_function (
    input  logic [0:31] i_word,
    output logic [0:31] o_word
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Rotate left by one byte, then substitute each byte.
    assign o_word = {SBOX[i_word[8:15]], SBOX[i_word[16:23]], SBOX[i_word[24:31]], SBOX[i_word[0:7]]};

endmodule

// File: rtl/aes128_key_expander.sv
// rtl/aes128_key_expander.sv - iterative AES-128 round-key sequencer, one key per handshake
module aes128_key_expander
    import aes128_key_expander_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_NUM_ROUNDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes128_key_expander_if.slave  bus
);

    state_t       r_state, w_next_state;
    logic [0:127] r_round_key, w_next_key, w_expanded;
    logic [3:0]   r_round_idx, w_next_idx;
    logic [7:0]   r_rcon, w_next_rcon;
    logic         r_rk_valid, w_next_valid;
    logic         r_done, w_next_done;
    logic [0:31]  w_g, w_w4, w_w5, w_w6, w_w7;
    logic         w_last;

    aes128_key_expander_g_function u_g_function (
        .i_word (r_round_key[96:127]),
        .o_word (w_g)
    );

    // rcon only touches the leading byte of G(w3); the rest is a straight XOR chain.
    assign w_w4       = r_round_key[0:31] ^ w_g ^ {r_rcon, 24'h000000};
    assign w_w5       = w_w4 ^ r_round_key[32:63];
    assign w_w6       = w_w5 ^ r_round_key[64:95];
    assign w_w7       = w_w6 ^ r_round_key[96:127];
    assign w_expanded = {w_w4, w_w5, w_w6, w_w7};
    assign w_last     = (r_round_idx == 4'(NUM_ROUNDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_round_key <= '0;
            r_round_idx <= '0;
            r_rcon      <= RCON_INIT;
            r_rk_valid  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_round_key <= w_next_key;
            r_round_idx <= w_next_idx;
            r_rcon      <= w_next_rcon;
            r_rk_valid  <= w_next_valid;
            r_done      <= w_next_done;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_key   = r_round_key;
        w_next_idx   = r_round_idx;
        w_next_rcon  = r_rcon;
        w_next_valid = r_rk_valid;
        w_next_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_EMIT;
                    w_next_key   = bus.key_in;
                    w_next_idx   = '0;
                    w_next_rcon  = RCON_INIT;
                    w_next_valid = 1'b1;
                end
            end
            ST_EMIT: begin
                if (r_rk_valid && bus.rk_ready) begin
                    if (w_last) begin
                        w_next_state = ST_IDLE;
                        w_next_valid = 1'b0;
                        w_next_done  = 1'b1;
                    end else begin
                        w_next_key  = w_expanded;
                        w_next_idx  = r_round_idx + 4'd1;
                        w_next_rcon = xtime(r_rcon);
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign bus.round_key = r_round_key;
    assign bus.round_idx = r_round_idx;
    assign bus.rk_valid  = r_rk_valid;
    assign bus.busy      = (r_state == ST_EMIT);
    assign bus.done      = r_done;

endmodule

// File: doc/aes128_key_expander.md
Name: aes128_key_expander

Overview:
Iterative AES-128 key-expansion sequencer. It consumes the 32-bit RotWord+SubWord result of the existing G_Function block and applies RCON. It then XOR-chains the four words to produce round keys 0..10, one per handshake. It sits between key load and the round datapath, which pulls one round key per valid/ready transfer.

Parameters:
NUM_ROUNDS, 10, number of round keys after key 0. Fixed for AES-128; any other value is unsupported.

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      asynchronous, active-low reset
start      input   1      load key_in and begin expansion; honoured only in IDLE
key_in     input   [0:127] cipher key; bits [0:31]=w0, [96:127]=w3, byte 0 at [0:7]
round_key  output  [0:127] current round key, same word/byte order as key_in
round_idx  output  [3:0]  index of round_key, 0..10
rk_valid   output  1      round_key/round_idx are valid
rk_ready   input   1      consumer accepts round_key this cycle
busy       output  1      expansion in progress (state != IDLE)
done       output  1      one-cycle pulse after key 10 is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE; round_key=0, round_idx=0, rk_valid=0, busy=0, done=0, rcon register=0x01.
- Reset mid-expansion aborts immediately. No partial key survives, and the next start restarts from key 0.
- States: IDLE, EMIT.
- IDLE -> EMIT on start=1:
  - Register round_key<=key_in, round_idx<=0, rcon<=0x01, rk_valid<=1.
  - Latency from start to key 0 valid: 1 cycle.
- EMIT, rk_valid && !rk_ready: hold round_key, round_idx and rcon stable (no change in any output).
- EMIT, handshake with round_idx<10:
  - g = G(w3). rcon is XORed into g[0:7] only.
  - w4 = w0^g, w5 = w4^w1, w6 = w5^w2, w7 = w6^w3.
  - Register round_key<={w4,w5,w6,w7}, round_idx<=round_idx+1, rcon<=xtime(rcon) (x2 in GF(2^8), reduce by 0x1B).
  - rk_valid stays 1, so throughput is one key per cycle with rk_ready held high.
- EMIT, handshake with round_idx==10: state<=IDLE, rk_valid<=0, done<=1 for exactly one cycle. round_key keeps key 10.
- start in EMIT is ignored; the expansion is not restarted.
- start in the cycle done=1 (already IDLE) is accepted.
- rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36. Wrap 0x80->0x1B comes via xtime.
- rk_ready while rk_valid=0 has no effect.
- key_in is sampled only on the accepted start cycle; later changes are ignored.
- Critical path: G (4 S-boxes) + 4-deep XOR chain, single cycle, no internal pipelining.

Decomposition:
- Shared AES package:
  - AES128_NUM_ROUNDS=10.
  - RCON_INIT=8'h01.
  - GF reduction constant 8'h1B.
  - xtime function.
  - state encoding (IDLE, EMIT).
- One sub-module, G_Function, instantiated unchanged on w3 (round_key[96:127]); its S-boxes come with it.
- RCON XOR, word chaining and FSM stay in this block.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, then start:
   - key0 = key, one cycle after start.
   - key1 = a0fafe1788542cb123a339392a6c7605.
   - key2 = f2c295f27a96b9435935807a7359f67f.
   - key10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - done pulses 11 cycles after key0 valid; busy=0 afterwards.
2. All-zero key:
   - key1 = 62636363626363636263636362636363.
   - key10 = b4ef5bcb3e92e21123e951cf6f8f188e (checks rcon 0x80->0x1B->0x36 wrap).
3. Backpressure, FIPS key with rk_ready random (~50%):
   - Same 11 keys in order, none skipped or repeated.
   - round_key/round_idx stable whenever valid && !ready.
4. start pulsed while busy (at round_idx=4) with a different key_in: ignored; sequence completes with the original key's key5..key10.
5. rst_n asserted at round_idx=6 with rk_valid=1:
   - All outputs zero immediately (asynchronous).
   - After release, start with zero key yields key1 = 6263...6363 (rcon reset to 0x01).
6. start asserted in the done cycle: key0 of the new key is valid on the next cycle and no extra done pulse appears.
